// File: rtl/bin_to_rns_conv64_18_if.sv
// Operand/result bundle for the 64-bit binary to six-digit RNS forward converter.
// The master drives the operand and consumes the residues. The slave is the converter.
interface bin_to_rns_conv64_18_if;
  logic [63:0] bin_in;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] RNS_D1_out;
  logic [17:0] RNS_D2_out;
  logic [17:0] RNS_D3_out;
  logic [17:0] RNS_D4_out;
  logic [17:0] RNS_D5_out;
  logic [17:0] RNS_D6_out;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output bin_in, in_valid, out_ready,
    input  in_ready, out_valid,
    input  RNS_D1_out, RNS_D2_out, RNS_D3_out, RNS_D4_out, RNS_D5_out, RNS_D6_out
  );

  modport slave (
    input  bin_in, in_valid, out_ready,
    output in_ready, out_valid,
    output RNS_D1_out, RNS_D2_out, RNS_D3_out, RNS_D4_out, RNS_D5_out, RNS_D6_out
  );
endinterface

// File: rtl/bin_to_rns_conv64_18.sv
// Forward converter: signed 64-bit two's-complement word -> six 18-bit RNS residues.
// The magnitude is folded into each residue with a radix-4 Horner recurrence,
// two bits per cycle and MSB first (32 cycles). A final step negates the
// non-zero residues of negative operands. Each step is a constant three-way
// compare/subtract, so no multipliers or tables are needed.
module bin_to_rns_conv64_18 #(
  parameter int MOD1 = 131072,
  parameter int MOD2 = 78125,
  parameter int MOD3 = 177147,
  parameter int MOD4 = 117649,
  parameter int MOD5 = 161051,
  parameter int MOD6 = 28561
) (
  input  logic                         clk,
  input  logic                         reset_n,
  bin_to_rns_conv64_18_if.slave        bus
);

  localparam int NUM_DIGITS = 6;

  // Lets the per-digit generate loop pick its modulus by index.
  function automatic int mod_sel(input int idx);
    case (idx)
      0:       return MOD1;
      1:       return MOD2;
      2:       return MOD3;
      3:       return MOD4;
      4:       return MOD5;
      default: return MOD6;
    endcase
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [63:0] mag_reg;
  logic        sign_reg;
  logic [4:0]  cnt_reg;
  logic        in_ready_reg;
  logic        out_valid_reg;

  logic        accept;
  logic [63:0] mag_abs;
  logic [1:0]  horner_bits;
  logic [17:0] res_q [NUM_DIGITS];

  // An operand is only taken in IDLE. in_valid is ignored everywhere else.
  assign accept = (state_reg == IDLE) && bus.in_valid;

  // Two's-complement magnitude. -2^63 maps to 2^63, which fits in 64 unsigned bits.
  assign mag_abs = bus.bin_in[63] ? (~bus.bin_in + 64'd1) : bus.bin_in;

  // The next radix-4 digit of the magnitude, MSB first.
  assign horner_bits = mag_reg[63:62];

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. The counter ends ITER after its 32nd cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          state_next = ITER;
        end
      end
      ITER: begin
        if (cnt_reg == 5'd0) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Registered handshake flags that follow the state the FSM is entering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      in_ready_reg  <= (state_next == IDLE);
      out_valid_reg <= (state_next == DONE);
    end
  end

  // Operand capture, then a two-bit shift of the magnitude and a counter step per ITER cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mag_reg  <= '0;
      sign_reg <= 1'b0;
      cnt_reg  <= '0;
    end else if (accept) begin
      mag_reg  <= mag_abs;
      sign_reg <= bus.bin_in[63];
      cnt_reg  <= 5'd31;
    end else if (state_reg == ITER) begin
      mag_reg  <= {mag_reg[61:0], 2'b00};
      cnt_reg  <= cnt_reg - 5'd1;
    end
  end

  // Digit datapath. Each digit runs its own Horner recurrence and sign fix.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    localparam logic [19:0] MOD_X1 = 20'(mod_sel(gi));
    localparam logic [19:0] MOD_X2 = 20'(2 * mod_sel(gi));
    localparam logic [19:0] MOD_X3 = 20'(3 * mod_sel(gi));

    logic [17:0] r_reg;
    logic [19:0] t_sum;
    logic [17:0] r_step;
    logic [17:0] r_neg;

    // t < 4*MOD because r < MOD, so one of four constant offsets brings it back below MOD.
    assign t_sum = {r_reg, 2'b00} + {18'd0, horner_bits};

    // Largest multiple of the modulus that does not exceed t. The three compares run in parallel.
    always_comb begin
      r_step = 18'(t_sum);
      if (t_sum >= MOD_X3) begin
        r_step = 18'(t_sum - MOD_X3);
      end else if (t_sum >= MOD_X2) begin
        r_step = 18'(t_sum - MOD_X2);
      end else if (t_sum >= MOD_X1) begin
        r_step = 18'(t_sum - MOD_X1);
      end
    end

    // The residue of -|x| is MOD - (|x| mod MOD). A zero residue stays zero.
    assign r_neg = MOD_X1[17:0] - r_reg;

    // Residue register. It clears on accept, steps in ITER, may negate in FIX, and holds otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_reg <= '0;
      end else if (accept) begin
        r_reg <= '0;
      end else if (state_reg == ITER) begin
        r_reg <= r_step;
      end else if ((state_reg == FIX) && sign_reg && (r_reg != '0)) begin
        r_reg <= r_neg;
      end
    end

    assign res_q[gi] = r_reg;
  end

  assign bus.in_ready   = in_ready_reg;
  assign bus.out_valid  = out_valid_reg;
  assign bus.RNS_D1_out = res_q[0];
  assign bus.RNS_D2_out = res_q[1];
  assign bus.RNS_D3_out = res_q[2];
  assign bus.RNS_D4_out = res_q[3];
  assign bus.RNS_D5_out = res_q[4];
  assign bus.RNS_D6_out = res_q[5];

endmodule

// File: tb/tb_bin_to_rns_conv64_18.sv
// Directed and random checks of the binary-to-RNS forward converter.
module tb_bin_to_rns_conv64_18;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  bin_to_rns_conv64_18_if dut_if ();

  bin_to_rns_conv64_18 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (dut_if.slave)
  );

  int checks = 0;
  int errors = 0;

  longint mods [6] = '{64'd131072, 64'd78125, 64'd177147, 64'd117649, 64'd161051, 64'd28561};

  typedef struct {
    string              name;
    longint             x;
    logic [5:0][17:0]   exp;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic longint get_res(input int k);
    case (k)
      0:       return longint'(dut_if.RNS_D1_out);
      1:       return longint'(dut_if.RNS_D2_out);
      2:       return longint'(dut_if.RNS_D3_out);
      3:       return longint'(dut_if.RNS_D4_out);
      4:       return longint'(dut_if.RNS_D5_out);
      default: return longint'(dut_if.RNS_D6_out);
    endcase
  endfunction

  // Reference model: ((x mod m) + m) mod m on signed 64-bit values.
  function automatic logic [5:0][17:0] model_exp(input longint x);
    logic [5:0][17:0] e;
    longint r;
    for (int k = 0; k < 6; k++) begin
      r = x % mods[k];
      if (r < 0) r = r + mods[k];
      e[k] = 18'(r);
    end
    return e;
  endfunction

  function automatic logic [5:0][17:0] pack6(input longint e0, e1, e2, e3, e4, e5);
    logic [5:0][17:0] e;
    e[0] = 18'(e0); e[1] = 18'(e1); e[2] = 18'(e2);
    e[3] = 18'(e3); e[4] = 18'(e4); e[5] = 18'(e5);
    return e;
  endfunction

  function automatic vec_t mk(input string nm, input longint x, input logic [5:0][17:0] e);
    vec_t v;
    v.name = nm;
    v.x    = x;
    v.exp  = e;
    return v;
  endfunction

  // One complete transaction: accept, latency, residues, optional backpressure, transfer.
  // Entered and left on a falling edge with the DUT expected to be in IDLE.
  task automatic do_conv(input string nm, input longint x, input logic [5:0][17:0] e,
                         input int hold, input bit pulse);
    int n;
    n = 0;
    while (!dut_if.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_in_ready_idle"}, longint'(dut_if.in_ready), 1);
    dut_if.bin_in    = x;
    dut_if.in_valid  = 1'b1;
    dut_if.out_ready = 1'b0;
    @(negedge clk);
    dut_if.in_valid = 1'b0;
    dut_if.bin_in   = '0;
    check({nm, "_in_ready_busy"}, longint'(dut_if.in_ready), 0);
    n = 0;
    while (!dut_if.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_latency"}, n, 33);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("%s_D%0d", nm, k + 1), get_res(k), longint'(e[k]));
    end
    for (int i = 0; i < hold; i++) begin
      dut_if.in_valid = pulse & i[0];
      dut_if.bin_in   = {$urandom, $urandom};
      @(negedge clk);
      check($sformatf("%s_hold%0d_in_ready", nm, i), longint'(dut_if.in_ready), 0);
      check($sformatf("%s_hold%0d_out_valid", nm, i), longint'(dut_if.out_valid), 1);
      for (int k = 0; k < 6; k++) begin
        check($sformatf("%s_hold%0d_D%0d", nm, i, k + 1), get_res(k), longint'(e[k]));
      end
    end
    dut_if.in_valid  = pulse;
    dut_if.out_ready = 1'b1;
    @(negedge clk);
    dut_if.in_valid  = 1'b0;
    dut_if.out_ready = 1'b0;
    dut_if.bin_in    = '0;
    check({nm, "_in_ready_after"}, longint'(dut_if.in_ready), 1);
    check({nm, "_out_valid_after"}, longint'(dut_if.out_valid), 0);
    check({nm, "_D1_held_after"}, get_res(0), longint'(e[0]));
    $display("conv %s x=%0d lat=%0d D=%0d,%0d,%0d,%0d,%0d,%0d", nm, x, n,
             get_res(0), get_res(1), get_res(2), get_res(3), get_res(4), get_res(5));
  endtask

  initial begin
    longint x;
    longint min_neg;
    logic [5:0][17:0] e;

    min_neg = 64'sh8000_0000_0000_0000;

    vecs.push_back(mk("zero",     64'sd0,      pack6(0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk("one",      64'sd1,      pack6(1, 1, 1, 1, 1, 1)));
    vecs.push_back(mk("x131072",  64'sd131072, pack6(0, 52947, 131072, 13423, 131072, 16828)));
    vecs.push_back(mk("x78125",   64'sd78125,  pack6(78125, 0, 78125, 78125, 78125, 21003)));
    vecs.push_back(mk("minus1",   -64'sd1,     pack6(131071, 78124, 177146, 117648, 161050, 28560)));
    e = model_exp(min_neg);
    e[0] = 18'd0;
    vecs.push_back(mk("min_neg",  min_neg,     e));
    vecs.push_back(mk("max_pos",  64'sh7FFF_FFFF_FFFF_FFFF, model_exp(64'sh7FFF_FFFF_FFFF_FFFF)));

    // Reset state.
    reset_n          = 1'b0;
    dut_if.bin_in    = '0;
    dut_if.in_valid  = 1'b0;
    dut_if.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", longint'(dut_if.in_ready), 1);
    check("reset_out_valid", longint'(dut_if.out_valid), 0);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("reset_D%0d", k + 1), get_res(k), 0);
    end
    reset_n = 1'b1;
    @(negedge clk);

    // Table-driven directed vectors.
    foreach (vecs[i]) begin
      do_conv(vecs[i].name, vecs[i].x, vecs[i].exp, 0, 1'b0);
    end

    // Backpressure for 10 cycles in DONE with in_valid pulsing, then a single transfer.
    do_conv("backpressure", -64'sd1, pack6(131071, 78124, 177146, 117648, 161050, 28560), 10, 1'b1);
    @(negedge clk);
    check("bp_no_extra_accept", longint'(dut_if.in_ready), 1);

    // Reset asserted 10 cycles after an accept aborts the conversion.
    dut_if.bin_in   = 64'sh8765_4321_0FED_CBA9;
    dut_if.in_valid = 1'b1;
    @(negedge clk);
    dut_if.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset_in_ready", longint'(dut_if.in_ready), 1);
    check("midreset_out_valid", longint'(dut_if.out_valid), 0);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("midreset_D%0d", k + 1), get_res(k), 0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_conv("post_reset_5", 64'sd5, pack6(5, 5, 5, 5, 5, 5), 0, 1'b0);

    // Random signed operands with random backpressure gaps.
    for (int i = 0; i < 200; i++) begin
      x = {$urandom, $urandom};
      do_conv($sformatf("rnd%0d", i), x, model_exp(x), $urandom_range(0, 3), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
